// File: rtl/config_dac_pkg.sv
// -----------------------------------------------------------------------------
// config_dac_pkg
// Shared definitions for the serial DAC configuration sequencer:
//   - state_t : sequencer FSM encoding (IDLE -> SHIFT -> GAP -> IDLE)
//   - CHAN_W  : width of the channel field carried in every frame
//   - frame_w : frame length in bits for a given DAC code width
// -----------------------------------------------------------------------------
package config_dac_pkg;

    localparam int CHAN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // A frame is the channel field followed by the DAC code.
    function automatic int frame_w(input int data_w);
        return CHAN_W + data_w;
    endfunction

endpackage

// File: rtl/config_dac_fifo.sv
// -----------------------------------------------------------------------------
// config_dac_fifo
// Small first-word-fall-through request FIFO. A push and a pop in the same
// cycle are both honoured, including when the FIFO is full.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      write strobe and data (caller never pushes when full
//                    unless popping in the same cycle)
//   pop              read strobe (caller never pops when empty)
//   rdata            head entry, valid while empty is low
//   full, empty      occupancy flags
// -----------------------------------------------------------------------------
module config_dac_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/config_dac_seq.sv
// -----------------------------------------------------------------------------
// config_dac_seq
// Accepts toggle-style configuration requests, queues {channel, code} frames
// and shifts each one out MSB first on a 3-wire DAC interface.
// Optional feature macro: CONFIG_DAC_READBACK_EN keeps a per-channel shadow of
// the last completed code, read combinationally through rd_chan_i/rd_data_o.
// Without it rd_data_o is tied to zero.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_req_i             request toggle; every level change is one request
//   cfg_chan_i/cfg_data_i target channel and DAC code, sampled with the request
//   cfg_busy_o            FIFO non-empty or frame in progress
//   cfg_done_o            one-cycle pulse per completed frame
//   cfg_err_o             sticky: [0] FIFO overflow, [1] invalid channel
//   dac_sclk_o            serial clock, idle low
//   dac_sync_n_o          frame select, active low
//   dac_sdi_o             serial data, MSB first
//   rd_chan_i/rd_data_o   shadow readback
// -----------------------------------------------------------------------------
module config_dac_seq
    import config_dac_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_req_i,
    input  logic [7:0]        cfg_chan_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    output logic [1:0]        cfg_err_o,
    output logic              dac_sclk_o,
    output logic              dac_sync_n_o,
    output logic              dac_sdi_o,
    input  logic [7:0]        rd_chan_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    state_t             state_q, state_d;
    logic               req_q;
    logic               strobe;
    logic               chan_ok;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_W-1:0] fifo_rdata;
    logic [FRAME_W-1:0] shreg;
    logic [7:0]         div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sclk_q;
    logic               div_last;

    assign strobe    = cfg_req_i ^ req_q;
    assign chan_ok   = ({1'b0, cfg_chan_i} < 9'(NUM_CH));
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign fifo_push = strobe && chan_ok && (!fifo_full || fifo_pop);
    assign div_last  = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            cfg_err_o <= 2'b00;
        end else begin
            req_q        <= cfg_req_i;
            cfg_err_o[0] <= cfg_err_o[0] | (strobe && chan_ok && fifo_full && !fifo_pop);
            cfg_err_o[1] <= cfg_err_o[1] | (strobe && !chan_ok);
        end
    end

    config_dac_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({cfg_chan_i, cfg_data_i}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_SHIFT;
            ST_SHIFT: if (div_last && sclk_q && (bit_cnt == BIT_LAST)) state_d = ST_GAP;
            ST_GAP:   if (div_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bit timing: each bit is CLK_DIV cycles with SCLK low, then CLK_DIV high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_q  <= !sclk_q;
                        if (sclk_q) bit_cnt <= bit_cnt + BIT_W'(1);
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
                    sclk_q  <= 1'b0;
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next bit is presented at the falling SCLK edge that ends each bit.
    always_ff @(posedge clk) begin
        if (fifo_pop)
            shreg <= fifo_rdata;
        else if ((state_q == ST_SHIFT) && div_last && sclk_q)
            shreg <= shreg << 1;
    end

    // Outputs decode registered state only, so reset forces idle levels at once.
    assign dac_sync_n_o = (state_q != ST_SHIFT);
    assign dac_sclk_o   = (state_q == ST_SHIFT) && sclk_q;
    assign dac_sdi_o    = (state_q == ST_SHIFT) && shreg[FRAME_W-1];
    assign cfg_done_o   = (state_q == ST_GAP) && div_last;
    assign cfg_busy_o   = !fifo_empty || (state_q != ST_IDLE);

`ifdef CONFIG_DAC_READBACK_EN
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [IDX_W-1:0]  cur_chan;
    logic [DATA_W-1:0] cur_data;

    // The shift register is consumed while shifting, so keep the frame's
    // channel and code aside for the shadow update at completion.
    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            cur_chan <= fifo_rdata[DATA_W +: IDX_W];
            cur_data <= fifo_rdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else if (cfg_done_o) begin
            shadow[cur_chan] <= cur_data;
        end
    end

    assign rd_data_o = ({1'b0, rd_chan_i} < 9'(NUM_CH)) ? shadow[rd_chan_i[IDX_W-1:0]] : '0;
`else
    logic unused_rd;
    assign unused_rd = ^rd_chan_i;
    assign rd_data_o = '0;
`endif

endmodule

// File: tb/tb_config_dac_seq.sv
module tb_config_dac_seq;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 4;
    localparam int CLK_DIV   = 4;
    localparam int FRAME_W   = 8 + DATA_W;
    localparam int FRAME_CYC = 2 * CLK_DIV * FRAME_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_req_i;
    logic [7:0]        cfg_chan_i;
    logic [DATA_W-1:0] cfg_data_i;
    logic              cfg_busy_o;
    logic              cfg_done_o;
    logic [1:0]        cfg_err_o;
    logic              dac_sclk_o;
    logic              dac_sync_n_o;
    logic              dac_sdi_o;
    logic [7:0]        rd_chan_i;
    logic [DATA_W-1:0] rd_data_o;

    always #5 clk = ~clk;

    config_dac_seq #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_req_i    (cfg_req_i),
        .cfg_chan_i   (cfg_chan_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_busy_o   (cfg_busy_o),
        .cfg_done_o   (cfg_done_o),
        .cfg_err_o    (cfg_err_o),
        .dac_sclk_o   (dac_sclk_o),
        .dac_sync_n_o (dac_sync_n_o),
        .dac_sdi_o    (dac_sdi_o),
        .rd_chan_i    (rd_chan_i),
        .rd_data_o    (rd_data_o)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: queue occupancy plus a busy countdown for the serial
    // engine (a popped frame occupies FRAME_CYC + CLK_DIV cycles, after which
    // the next pop can happen at the following edge).
    logic [FRAME_W-1:0] mq[$];
    logic [FRAME_W-1:0] exp_frames[$];
    int                 eng;
    int                 m_pops;
    logic [1:0]         m_err;
    logic [DATA_W-1:0]  m_shadow [NUM_CH];

    // Monitor results
    int                 done_cnt;
    int                 frames_seen;
    int                 busy_cycles;
    int                 sclk_bad;
    logic [FRAME_W-1:0] last_frame;

    task automatic model_reset();
        mq.delete();
        exp_frames.delete();
        eng         = 0;
        m_pops      = 0;
        m_err       = 2'b00;
        for (int i = 0; i < NUM_CH; i++) m_shadow[i] = '0;
        done_cnt    = 0;
        frames_seen = 0;
        busy_cycles = 0;
        sclk_bad    = 0;
        last_frame  = '0;
    endtask

    task automatic cyc(input bit tog, input int ch, input logic [DATA_W-1:0] d);
        bit pop, ok, acc;
        @(negedge clk);
        if (tog) begin
            cfg_chan_i = 8'(ch);
            cfg_data_i = d;
            cfg_req_i  = ~cfg_req_i;
        end
        @(posedge clk);
        pop = (eng == 0) && (mq.size() > 0);
        ok  = tog && (ch < NUM_CH);
        acc = ok && ((mq.size() < DEPTH) || pop);
        if (pop) begin
            exp_frames.push_back(mq.pop_front());
            eng = FRAME_CYC + CLK_DIV;
            m_pops++;
        end else if (eng > 0) begin
            eng--;
        end
        if (acc) mq.push_back({8'(ch), d});
        if (tog && !ok) m_err[1] = 1'b1;
        if (ok && !acc) m_err[0] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cfg_req_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && !(mq.size() == 0 && eng == 0); i++) cyc(0, 0, '0);
        repeat (3) cyc(0, 0, '0);
        check({tag, "_busy_idle"}, cfg_busy_o, 1'b0);
        check({tag, "_frames_pending"}, exp_frames.size(), 0);
        check({tag, "_sclk_idle_low"}, sclk_bad, 0);
    endtask

    task automatic check_rb(input string tag);
        logic [DATA_W-1:0] e;
        for (int c = 0; c <= NUM_CH; c++) begin
            rd_chan_i = 8'(c);
            #1;
`ifdef CONFIG_DAC_READBACK_EN
            e = (c < NUM_CH) ? m_shadow[c] : '0;
`else
            e = '0;
`endif
            check($sformatf("%s_rb_ch%0d", tag, c), rd_data_o, e);
        end
    endtask

    // Monitor: deserialise SDI on SCLK rising edges during sync_n low and
    // compare each finished frame with the head of the expected queue.
    initial begin
        logic               prev_sync = 1'b1;
        logic               prev_sclk = 1'b0;
        logic               in_frame  = 1'b0;
        logic [FRAME_W-1:0] shv = '0;
        logic [FRAME_W-1:0] e;
        int                 nb  = 0;
        int                 low = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 1'b0;
                prev_sync = 1'b1;
                prev_sclk = 1'b0;
            end else begin
                if (!dac_sync_n_o) begin
                    if (prev_sync) begin
                        in_frame = 1'b1;
                        shv = '0;
                        nb  = 0;
                        low = 0;
                    end
                    low++;
                    if (dac_sclk_o && !prev_sclk) begin
                        shv = {shv[FRAME_W-2:0], dac_sdi_o};
                        nb++;
                    end
                end else begin
                    if (dac_sclk_o) sclk_bad++;
                    if (!prev_sync && in_frame) begin
                        in_frame = 1'b0;
                        check("frame_len_cycles", low, FRAME_CYC);
                        check("frame_bit_count", nb, FRAME_W);
                        if (exp_frames.size() == 0) begin
                            check("unexpected_frame", shv, 'x);
                        end else begin
                            e = exp_frames.pop_front();
                            check("frame_data", shv, e);
                        end
                        last_frame = shv;
                        if (shv[DATA_W +: 8] < NUM_CH) m_shadow[shv[DATA_W +: 8]] = shv[DATA_W-1:0];
                        frames_seen++;
                    end
                end
                if (cfg_done_o) done_cnt++;
                if (cfg_busy_o) busy_cycles++;
                prev_sync = dac_sync_n_o;
                prev_sclk = dac_sclk_o;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        cfg_req_i  = 1'b0;
        cfg_chan_i = '0;
        cfg_data_i = '0;
        rd_chan_i  = 8'd2;
        model_reset();
        #1;
        check("rst_sync_n", dac_sync_n_o, 1'b1);
        check("rst_sclk", dac_sclk_o, 1'b0);
        check("rst_sdi", dac_sdi_o, 1'b0);
        check("rst_busy", cfg_busy_o, 1'b0);
        check("rst_done", cfg_done_o, 1'b0);
        check("rst_err", cfg_err_o, 2'b00);
        check("rst_rd_data", rd_data_o, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single frame on channel 2: latency, content, done, readback.
        cyc(1, 2, 16'hA5C3);
        #1 check("lat_1cyc_sync_high", dac_sync_n_o, 1'b1);
        cyc(0, 0, '0);
        #1 check("lat_2cyc_sync_low", dac_sync_n_o, 1'b0);
        check("first_bit_msb", dac_sdi_o, 1'b0);
        wait_idle("single");
        check("single_frame", last_frame, 24'h02A5C3);
        check("single_done_cnt", done_cnt, 1);
        check("single_err", cfg_err_o, 2'b00);
        check_rb("single");

        // Five requests in consecutive cycles while idle: no overflow.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, i % NUM_CH, DATA_W'($urandom));
        wait_idle("burst5");
        check("burst5_done_cnt", done_cnt, 5);
        check("burst5_frames", frames_seen, 5);
        check("burst5_err", cfg_err_o, 2'b00);
        check_rb("burst5");

        // Six requests while a frame is shifting: four queue, two overflow.
        do_reset();
        cyc(1, 1, DATA_W'($urandom));
        repeat (20) cyc(0, 0, '0);
        for (int i = 0; i < 6; i++) cyc(1, $urandom_range(0, NUM_CH - 1), DATA_W'($urandom));
        #1 check("ovf_err_flag", cfg_err_o, 2'b01);
        wait_idle("ovf");
        check("ovf_done_cnt", done_cnt, 5);
        check("ovf_err_sticky", cfg_err_o, 2'b01);
        check_rb("ovf");

        // Invalid channel: dropped, flagged, never busy.
        do_reset();
        cyc(1, NUM_CH, 16'h1234);
        repeat (10) cyc(0, 0, '0);
        check("badch_err", cfg_err_o, 2'b10);
        check("badch_busy_cycles", busy_cycles, 0);
        check("badch_done_cnt", done_cnt, 0);
        check("badch_frames", frames_seen, 0);

        // Reset during bit 10 of a frame: immediate idle levels, no completion.
        do_reset();
        cyc(1, 3, 16'hBEEF);
        repeat (1 + 10 * 2 * CLK_DIV + 3) cyc(0, 0, '0);
        #2;
        check("abort_pre_sync_low", dac_sync_n_o, 1'b0);
        rst_n     = 1'b0;
        cfg_req_i = 1'b0;
        #1;
        check("abort_sync_n", dac_sync_n_o, 1'b1);
        check("abort_sclk", dac_sclk_o, 1'b0);
        check("abort_sdi", dac_sdi_o, 1'b0);
        check("abort_busy", cfg_busy_o, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) cyc(0, 0, '0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_frames", frames_seen, 0);
        rd_chan_i = 8'd3;
        #1 check("abort_rb_ch3", rd_data_o, '0);

        // Randomised traffic including invalid channels and overflow bursts.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 400) : $urandom_range(0, 3);
            repeat (gap) cyc(0, 0, '0);
            cyc(1, $urandom_range(0, NUM_CH + 1), DATA_W'($urandom));
        end
        wait_idle("rand");
        check("rand_err", cfg_err_o, m_err);
        check("rand_done_cnt", done_cnt, m_pops);
        check("rand_frames", frames_seen, m_pops);
        check_rb("rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
